// File: rtl/uplink_regs_pkg.sv
// Shared constants, response helper and FSM state types for the Uplink AXI4-Lite register bank.
package uplink_regs_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned WORD_BYTES = WORD_W / 8;
  localparam int unsigned NUM_REGS   = 4;

  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_1    = 2'd1;
  localparam logic [1:0] REG_2    = 2'd2;
  localparam logic [1:0] REG_3    = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    W_IDLE   = 3'd0,
    W_GOT_AW = 3'd1,
    W_GOT_W  = 3'd2,
    W_COMMIT = 3'd3,
    W_RESP   = 3'd4
  } w_state_t;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

  // Unmapped accesses only report SLVERR when the error option is built in.
  function automatic logic [1:0] resp_for(input logic mapped, input logic slverr_en);
    return (mapped || !slverr_en) ? RESP_OKAY : RESP_SLVERR;
  endfunction

endpackage

// File: rtl/uplink_regs_strobe_merge.sv
// Byte-lane merge: lanes with strb set take new_word, the rest keep old_word.
module uplink_regs_strobe_merge
  import uplink_regs_pkg::*;
(
  input  logic [WORD_W-1:0]     old_word,
  input  logic [WORD_W-1:0]     new_word,
  input  logic [WORD_BYTES-1:0] strb,
  output logic [WORD_W-1:0]     merged
);

  always_comb begin
    merged = old_word;
    for (int b = 0; b < WORD_BYTES; b++) begin
      if (strb[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
  end

endmodule

// File: rtl/uplink_axil_regs.sv
// AXI4-Lite slave with four config registers and a start strobe for the uplink datapath.
// Build option UPLINK_REGS_SLVERR_EN: unmapped word indices answer SLVERR instead of OKAY.
//
// state    | meaning
// W_IDLE   | both AW and W accepted
// W_GOT_AW | address held, waiting for W
// W_GOT_W  | data/strobe held, waiting for AW
// W_COMMIT | registers updated, start_pulse may fire
// W_RESP   | BVALID until BREADY
// R_IDLE   | AR accepted
// R_DATA   | RVALID until RREADY
module uplink_axil_regs
  import uplink_regs_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg_reg0,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg_reg1,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg_reg2,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg_reg3,
  output logic                            start_pulse
);

`ifdef UPLINK_REGS_SLVERR_EN
  localparam logic SLVERR_EN = 1'b1;
`else
  localparam logic SLVERR_EN = 1'b0;
`endif

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic [WORD_W-1:0]     regs   [NUM_REGS];
  logic [WORD_W-1:0]     merged [NUM_REGS];
  logic [2:0]            aw_idx_q;
  logic [2:0]            ar_idx;
  logic [WORD_W-1:0]     wdata_q;
  logic [WORD_BYTES-1:0] wstrb_q;
  logic                  aw_mapped, ar_mapped;
  logic                  aw_hs, w_hs, ar_hs;
  logic                  awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
  logic [1:0]            bresp_q, rresp_q;
  logic [WORD_W-1:0]     rdata_q;
  logic                  unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Handshakes use the registered readies so nothing is accepted in the cycle reset releases.
  assign aw_hs = S_AXI_AWVALID && awready_q;
  assign w_hs  = S_AXI_WVALID && wready_q;
  assign ar_hs = S_AXI_ARVALID && arready_q;

  assign ar_idx    = S_AXI_ARADDR[4:2];
  assign aw_mapped = ({29'd0, aw_idx_q} < NUM_REGS);
  assign ar_mapped = ({29'd0, ar_idx} < NUM_REGS);

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_merge
    uplink_regs_strobe_merge u_merge (
      .old_word (regs[g]),
      .new_word (wdata_q),
      .strb     (wstrb_q),
      .merged   (merged[g])
    );
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE: begin
        if (aw_hs && w_hs) w_next = W_COMMIT;
        else if (aw_hs)    w_next = W_GOT_AW;
        else if (w_hs)     w_next = W_GOT_W;
      end
      W_GOT_AW: if (w_hs)  w_next = W_COMMIT;
      W_GOT_W:  if (aw_hs) w_next = W_COMMIT;
      W_COMMIT:            w_next = W_RESP;
      W_RESP:   if (S_AXI_BREADY) w_next = W_IDLE;
      default:             w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state   <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      aw_idx_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      w_state   <= w_next;
      awready_q <= (w_next == W_IDLE) || (w_next == W_GOT_W);
      wready_q  <= (w_next == W_IDLE) || (w_next == W_GOT_AW);
      bvalid_q  <= (w_next == W_RESP);
      if (aw_hs) aw_idx_q <= S_AXI_AWADDR[4:2];
      if (w_hs) begin
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
      if (w_state == W_COMMIT) bresp_q <= resp_for(aw_mapped, SLVERR_EN);
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (w_state == W_COMMIT && aw_mapped) begin
      regs[aw_idx_q[1:0]] <= merged[aw_idx_q[1:0]];
    end
  end

  assign start_pulse = (w_state == W_COMMIT) && aw_mapped && (aw_idx_q[1:0] == REG_CTRL)
                       && wstrb_q[0] && wdata_q[0];

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_DATA;
      R_DATA:  if (S_AXI_RREADY) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // A read that lands on the commit edge samples regs before the write takes effect.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state   <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state   <= r_next;
      arready_q <= (r_next == R_IDLE);
      rvalid_q  <= (r_next == R_DATA);
      if (ar_hs) begin
        rdata_q <= ar_mapped ? regs[ar_idx[1:0]] : '0;
        rresp_q <= resp_for(ar_mapped, SLVERR_EN);
      end
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;

  assign cfg_reg0 = regs[REG_CTRL];
  assign cfg_reg1 = regs[REG_1];
  assign cfg_reg2 = regs[REG_2];
  assign cfg_reg3 = regs[REG_3];

endmodule

// File: tb/tb_uplink_axil_regs.sv
// Directed self-checking bench for uplink_axil_regs; expected values are hand-computed constants.
module tb_uplink_axil_regs;

`ifdef UPLINK_REGS_SLVERR_EN
  localparam logic [1:0] EXP_UNMAPPED = 2'b10;
`else
  localparam logic [1:0] EXP_UNMAPPED = 2'b00;
`endif

  logic        ACLK, ARESETN;
  logic [4:0]  S_AXI_AWADDR, S_AXI_ARADDR;
  logic [2:0]  S_AXI_AWPROT, S_AXI_ARPROT;
  logic        S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
  logic [31:0] S_AXI_WDATA, S_AXI_RDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
  logic        S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
  logic        S_AXI_RVALID, S_AXI_RREADY;
  logic [31:0] cfg_reg0, cfg_reg1, cfg_reg2, cfg_reg3;
  logic        start_pulse;

  int tests  = 0;
  int errors = 0;
  int sp_count = 0;
  int bv_hs_count = 0;
  int bv_high_cycles = 0;

  uplink_axil_regs dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .cfg_reg0(cfg_reg0), .cfg_reg1(cfg_reg1), .cfg_reg2(cfg_reg2), .cfg_reg3(cfg_reg3),
    .start_pulse(start_pulse)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  always @(posedge ACLK) begin
    if (start_pulse) sp_count <= sp_count + 1;
    if (S_AXI_BVALID && S_AXI_BREADY) bv_hs_count <= bv_hs_count + 1;
    if (S_AXI_BVALID) bv_high_cycles <= bv_high_cycles + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, output logic [1:0] resp);
    bit aw_pend = 1, w_pend = 1, aw_fire, w_fire, got = 0;
    int n = 0;
    resp = 2'bxx;
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    while ((aw_pend || w_pend) && n < 40) begin
      if (aw_pend && n >= aw_dly) S_AXI_AWVALID = 1'b1;
      if (w_pend && n >= w_dly)   S_AXI_WVALID  = 1'b1;
      @(negedge ACLK);
      aw_fire = S_AXI_AWVALID && S_AXI_AWREADY;
      w_fire  = S_AXI_WVALID && S_AXI_WREADY;
      @(posedge ACLK); #1;
      if (aw_fire) begin S_AXI_AWVALID = 1'b0; aw_pend = 0; end
      if (w_fire)  begin S_AXI_WVALID  = 1'b0; w_pend  = 0; end
      n++;
    end
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    if (aw_pend || w_pend) begin
      tests++; errors++;
      $display("FAIL write_handshake_timeout addr=%h aw_pend=%0d w_pend=%0d", addr, aw_pend, w_pend);
    end
    S_AXI_BREADY = 1'b1; n = 0;
    while (!got && n < 40) begin
      @(negedge ACLK);
      if (S_AXI_BVALID) begin got = 1; resp = S_AXI_BRESP; end
      @(posedge ACLK); #1;
      n++;
    end
    S_AXI_BREADY = 1'b0;
    if (!got) begin
      tests++; errors++;
      $display("FAIL write_resp_timeout addr=%h got no BVALID", addr);
    end
  endtask

  task automatic axi_read(input logic [4:0] addr, output logic [31:0] data, output logic [1:0] resp);
    bit fire = 0;
    int n = 0;
    data = 'x; resp = 'x;
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
    while (!fire && n < 40) begin
      @(negedge ACLK);
      fire = S_AXI_ARREADY;
      @(posedge ACLK); #1;
      n++;
    end
    S_AXI_ARVALID = 1'b0;
    if (!fire) begin
      tests++; errors++;
      $display("FAIL read_addr_timeout addr=%h", addr);
    end
    S_AXI_RREADY = 1'b1; fire = 0; n = 0;
    while (!fire && n < 40) begin
      @(negedge ACLK);
      if (S_AXI_RVALID) begin fire = 1; data = S_AXI_RDATA; resp = S_AXI_RRESP; end
      @(posedge ACLK); #1;
      n++;
    end
    S_AXI_RREADY = 1'b0;
    if (!fire) begin
      tests++; errors++;
      $display("FAIL read_data_timeout addr=%h", addr);
    end
  endtask

  task automatic test_reset();
    ARESETN = 1'b1;
    #2 ARESETN = 1'b0;
    repeat (3) @(posedge ACLK);
    #1;
    tests++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID, start_pulse} !== 6'b0) begin
      errors++;
      $display("FAIL reset_handshake got aw/w/ar rdy,bv,rv,sp=%b want 000000",
               {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID, start_pulse});
    end
    tests++;
    if ({cfg_reg0, cfg_reg1, cfg_reg2, cfg_reg3, S_AXI_RDATA, S_AXI_BRESP, S_AXI_RRESP} !== '0) begin
      errors++;
      $display("FAIL reset_values got cfg=%h %h %h %h rdata=%h bresp=%b rresp=%b want all zero",
               cfg_reg0, cfg_reg1, cfg_reg2, cfg_reg3, S_AXI_RDATA, S_AXI_BRESP, S_AXI_RRESP);
    end
    @(negedge ACLK);
    ARESETN = 1'b1;
    #1;
    tests++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b000) begin
      errors++;
      $display("FAIL ready_before_edge got %b want 000", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
    end
    @(posedge ACLK); #1;
    tests++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b111) begin
      errors++;
      $display("FAIL ready_after_edge got %b want 111", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
    end
  endtask

  task automatic test_basic_rw();
    logic [1:0]  resp;
    logic [31:0] rd;
    int sp0 = sp_count;
    for (int i = 0; i < 4; i++) begin
      axi_write(5'(i * 4), 32'(i + 1), 4'hF, 0, 0, resp);
      tests++;
      if (resp !== 2'b00) begin
        errors++; $display("FAIL basic_bresp idx=%0d got %b want 00", i, resp);
      end
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(5'(i * 4), rd, resp);
      tests++;
      if (rd !== 32'(i + 1) || resp !== 2'b00) begin
        errors++; $display("FAIL basic_read idx=%0d got %h/%b want %h/00", i, rd, resp, 32'(i + 1));
      end
    end
    tests++;
    if ({cfg_reg0, cfg_reg1, cfg_reg2, cfg_reg3} !== {32'd1, 32'd2, 32'd3, 32'd4}) begin
      errors++; $display("FAIL basic_cfg got %h %h %h %h want 1 2 3 4", cfg_reg0, cfg_reg1, cfg_reg2, cfg_reg3);
    end
    tests++;
    if (sp_count - sp0 !== 1) begin
      errors++; $display("FAIL basic_start_pulses got %0d want 1", sp_count - sp0);
    end
  endtask

  task automatic test_aw_w_order();
    logic [1:0] resp;
    int bv0 = bv_hs_count;
    axi_write(5'h08, 32'hDEADBEEF, 4'hF, 0, 3, resp);
    tests++;
    if (cfg_reg2 !== 32'hDEADBEEF || bv_hs_count - bv0 !== 1 || resp !== 2'b00) begin
      errors++; $display("FAIL aw_first got reg2=%h bresps=%0d resp=%b want deadbeef/1/00",
                         cfg_reg2, bv_hs_count - bv0, resp);
    end
    axi_write(5'h08, 32'h0, 4'hF, 0, 0, resp);
    tests++;
    if (cfg_reg2 !== 32'h0) begin
      errors++; $display("FAIL reg2_clear got %h want 00000000", cfg_reg2);
    end
    bv0 = bv_hs_count;
    axi_write(5'h08, 32'hDEADBEEF, 4'hF, 3, 0, resp);
    tests++;
    if (cfg_reg2 !== 32'hDEADBEEF || bv_hs_count - bv0 !== 1 || resp !== 2'b00) begin
      errors++; $display("FAIL w_first got reg2=%h bresps=%0d resp=%b want deadbeef/1/00",
                         cfg_reg2, bv_hs_count - bv0, resp);
    end
  endtask

  task automatic test_strobes();
    logic [1:0]  resp;
    logic [31:0] rd;
    int sp0;
    axi_write(5'h04, 32'hFFFFFFFF, 4'hF, 0, 0, resp);
    axi_write(5'h04, 32'h12345678, 4'b0101, 0, 0, resp);
    axi_read(5'h04, rd, resp);
    tests++;
    if (cfg_reg1 !== 32'hFF34FF78 || rd !== 32'hFF34FF78) begin
      errors++; $display("FAIL strobe_0101 got cfg=%h rd=%h want ff34ff78", cfg_reg1, rd);
    end
    axi_write(5'h04, 32'h00000000, 4'b1010, 0, 0, resp);
    tests++;
    if (cfg_reg1 !== 32'h00340078) begin
      errors++; $display("FAIL strobe_1010 got %h want 00340078", cfg_reg1);
    end
    axi_write(5'h05, 32'hFFFFFFFF, 4'b0000, 0, 0, resp);
    tests++;
    if (cfg_reg1 !== 32'h00340078) begin
      errors++; $display("FAIL strobe_none got %h want 00340078", cfg_reg1);
    end
    sp0 = sp_count;
    axi_write(5'h00, 32'h00000101, 4'b0010, 0, 0, resp);
    tests++;
    if (cfg_reg0 !== 32'h00000101 || sp_count - sp0 !== 0) begin
      errors++; $display("FAIL reg0_no_lane0 got reg0=%h pulses=%0d want 00000101/0", cfg_reg0, sp_count - sp0);
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    S_AXI_AWADDR = 5'h0C; S_AXI_WDATA = 32'h0BADF00D; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
    @(negedge ACLK);
    tests++;
    if ({S_AXI_AWREADY, S_AXI_WREADY} !== 2'b11) begin
      errors++; $display("FAIL bp_idle_ready got %b want 11", {S_AXI_AWREADY, S_AXI_WREADY});
    end
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    while (!S_AXI_BVALID && n < 10) begin @(posedge ACLK); #1; n++; end
    for (int i = 0; i < 10; i++) begin
      @(negedge ACLK);
      tests++;
      if (S_AXI_BVALID !== 1'b1 || S_AXI_BRESP !== 2'b00 || {S_AXI_AWREADY, S_AXI_WREADY} !== 2'b00) begin
        errors++; $display("FAIL bp_b_hold cyc=%0d got bv=%b bresp=%b rdy=%b want 1/00/00",
                           i, S_AXI_BVALID, S_AXI_BRESP, {S_AXI_AWREADY, S_AXI_WREADY});
      end
    end
    S_AXI_BREADY = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_BREADY = 1'b0;
    tests++;
    if (S_AXI_BVALID !== 1'b0 || S_AXI_AWREADY !== 1'b1 || cfg_reg3 !== 32'h0BADF00D) begin
      errors++; $display("FAIL bp_b_release got bv=%b awrdy=%b reg3=%h want 0/1/0badf00d",
                         S_AXI_BVALID, S_AXI_AWREADY, cfg_reg3);
    end
    S_AXI_ARADDR = 5'h0C; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
    @(posedge ACLK); #1;
    S_AXI_ARVALID = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge ACLK);
      tests++;
      if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== 32'h0BADF00D || S_AXI_RRESP !== 2'b00 || S_AXI_ARREADY !== 1'b0) begin
        errors++; $display("FAIL bp_r_hold cyc=%0d got rv=%b rdata=%h rresp=%b arrdy=%b want 1/0badf00d/00/0",
                           i, S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_ARREADY);
      end
    end
    S_AXI_RREADY = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_RREADY = 1'b0;
    tests++;
    if (S_AXI_RVALID !== 1'b0 || S_AXI_ARREADY !== 1'b1) begin
      errors++; $display("FAIL bp_r_release got rv=%b arrdy=%b want 0/1", S_AXI_RVALID, S_AXI_ARREADY);
    end
  endtask

  task automatic test_same_cycle_rw();
    S_AXI_AWADDR = 5'h00; S_AXI_WDATA = 32'h00000003; S_AXI_WSTRB = 4'b0001;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    S_AXI_ARADDR = 5'h00; S_AXI_ARVALID = 1'b1;
    @(negedge ACLK);
    tests++;
    if (start_pulse !== 1'b1 || S_AXI_ARREADY !== 1'b1) begin
      errors++; $display("FAIL commit_cycle got sp=%b arrdy=%b want 1/1", start_pulse, S_AXI_ARREADY);
    end
    @(posedge ACLK); #1;
    S_AXI_ARVALID = 1'b0;
    @(negedge ACLK);
    tests++;
    if (start_pulse !== 1'b0 || S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== 32'h00000101 || S_AXI_BVALID !== 1'b1) begin
      errors++; $display("FAIL pre_write_read got sp=%b rv=%b rdata=%h bv=%b want 0/1/00000101/1",
                         start_pulse, S_AXI_RVALID, S_AXI_RDATA, S_AXI_BVALID);
    end
    tests++;
    if (cfg_reg0 !== 32'h00000103) begin
      errors++; $display("FAIL post_commit_reg0 got %h want 00000103", cfg_reg0);
    end
    S_AXI_RREADY = 1'b1; S_AXI_BREADY = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_RREADY = 1'b0; S_AXI_BREADY = 1'b0;
    tests++;
    if ({S_AXI_RVALID, S_AXI_BVALID} !== 2'b00) begin
      errors++; $display("FAIL same_cycle_release got rv,bv=%b want 00", {S_AXI_RVALID, S_AXI_BVALID});
    end
  endtask

  task automatic test_unmapped();
    logic [1:0]  resp;
    logic [31:0] rd;
    int sp0 = sp_count;
    axi_write(5'h10, 32'hFFFFFFFF, 4'hF, 0, 0, resp);
    tests++;
    if (resp !== EXP_UNMAPPED) begin
      errors++; $display("FAIL unmapped_bresp got %b want %b", resp, EXP_UNMAPPED);
    end
    tests++;
    if ({cfg_reg0, cfg_reg1, cfg_reg2, cfg_reg3} !== {32'h00000103, 32'h00340078, 32'hDEADBEEF, 32'h0BADF00D}
        || sp_count - sp0 !== 0) begin
      errors++; $display("FAIL unmapped_write_effect got %h %h %h %h pulses=%0d want 103 340078 deadbeef badf00d 0",
                         cfg_reg0, cfg_reg1, cfg_reg2, cfg_reg3, sp_count - sp0);
    end
    axi_read(5'h10, rd, resp);
    tests++;
    if (rd !== 32'h0 || resp !== EXP_UNMAPPED) begin
      errors++; $display("FAIL unmapped_read_10 got %h/%b want 00000000/%b", rd, resp, EXP_UNMAPPED);
    end
    axi_read(5'h1C, rd, resp);
    tests++;
    if (rd !== 32'h0 || resp !== EXP_UNMAPPED) begin
      errors++; $display("FAIL unmapped_read_1c got %h/%b want 00000000/%b", rd, resp, EXP_UNMAPPED);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [1:0]  resp;
    logic [31:0] rd;
    int bvh0 = bv_high_cycles;
    S_AXI_AWADDR = 5'h00; S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b0;
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0;
    @(negedge ACLK);
    tests++;
    if ({S_AXI_AWREADY, S_AXI_WREADY} !== 2'b01) begin
      errors++; $display("FAIL got_aw_readies got %b want 01", {S_AXI_AWREADY, S_AXI_WREADY});
    end
    ARESETN = 1'b0;
    #1;
    tests++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID} !== 3'b000 || cfg_reg0 !== 32'h0) begin
      errors++; $display("FAIL mid_reset got rdy,bv=%b reg0=%h want 000/00000000",
                         {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID}, cfg_reg0);
    end
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    ARESETN = 1'b1;
    repeat (2) @(posedge ACLK);
    #1;
    axi_read(5'h00, rd, resp);
    tests++;
    if (rd !== 32'h0 || resp !== 2'b00) begin
      errors++; $display("FAIL post_reset_read got %h/%b want 00000000/00", rd, resp);
    end
    repeat (5) @(posedge ACLK);
    #1;
    tests++;
    if (bv_high_cycles - bvh0 !== 0) begin
      errors++; $display("FAIL post_reset_bvalid got %0d bvalid cycles want 0", bv_high_cycles - bvh0);
    end
  endtask

  initial begin
    S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
    test_reset();
    test_basic_rw();
    test_aw_w_order();
    test_strobes();
    test_backpressure();
    test_same_cycle_rw();
    test_unmapped();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
